hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/operand_use_decode.sv | 27 ++
 rtl/hazard_controller.sv | 170 +++++++++++++++++
 tb/tb_hazard_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: RV32I major opcodes and the hazard FSM state encoding.
package pipeline_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } hz_state_e;

    // Loads, stores, branches and jumps never have a usable ALU result in EX.
    function automatic logic ex_result_forwardable(input logic [6:0] opcode);
        return !(opcode inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR});
    endfunction

endpackage

// File: rtl/operand_use_decode.sv
// Extracts register specifiers from an instruction and flags which source registers it reads.
module operand_use_decode
    import pipeline_pkg::*;
(
    input  logic [31:0] instr,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);

    logic [6:0] opcode;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign uses_rs1 = !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    assign uses_rs2 = opcode inside {OPC_OP, OPC_STORE, OPC_BRANCH};

    // funct3/funct7 do not affect operand usage.
    assign unused_fields = ^{instr[14:12], instr[31:25]};

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard unit: EX->DE forwarding, load-use interlock, branch flush and
// data-memory freeze with timeout, plus a saturating stall-cycle counter.
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned BR_PENALTY  = 1,
    parameter int unsigned MEM_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_de,
    input  logic [31:0] instr_ex,
    input  logic        reg_write_ex,
    input  logic        br_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_if,
    output logic        stall_de,
    output logic        stall_ex,
    output logic        flush_de,
    output logic        flush_ex,
    output logic        fwd_a,
    output logic        fwd_b,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);

    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0] FLUSH_INIT = 2'(BR_PENALTY - 1);

    logic       uses_rs1_de, uses_rs2_de;
    logic [4:0] rs1_de, rs2_de, rd_de;
    logic       uses_rs1_ex, uses_rs2_ex;
    logic [4:0] rs1_ex, rs2_ex, rd_ex;
    logic       unused_decode;

    operand_use_decode u_decode_de (
        .instr    (instr_de),
        .uses_rs1 (uses_rs1_de),
        .uses_rs2 (uses_rs2_de),
        .rs1      (rs1_de),
        .rs2      (rs2_de),
        .rd       (rd_de)
    );

    operand_use_decode u_decode_ex (
        .instr    (instr_ex),
        .uses_rs1 (uses_rs1_ex),
        .uses_rs2 (uses_rs2_ex),
        .rs1      (rs1_ex),
        .rs2      (rs2_ex),
        .rd       (rd_ex)
    );

    assign unused_decode = ^{rd_de, uses_rs1_ex, uses_rs2_ex, rs1_ex, rs2_ex};

    logic [6:0] opcode_ex;
    logic       ex_fwd, match_rs1, match_rs2, load_use, mem_busy;

    assign opcode_ex = instr_ex[6:0];
    assign ex_fwd    = reg_write_ex && (rd_ex != 5'd0) && ex_result_forwardable(opcode_ex);
    assign match_rs1 = uses_rs1_de && (rs1_de == rd_ex);
    assign match_rs2 = uses_rs2_de && (rs2_de == rd_ex);
    assign load_use  = (opcode_ex == OPC_LOAD) && (rd_ex != 5'd0) && (match_rs1 || match_rs2);
    assign mem_busy  = dmem_req && !dmem_ready;

    hz_state_e   state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic        mem_err_q, mem_err_d;
    logic [31:0] stall_cnt_q;

    logic freeze, resolve, lu_stall, flush_de_c, flush_ex_c;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mem_err_d   = 1'b0;
        freeze      = 1'b0;
        resolve     = 1'b0;
        lu_stall    = 1'b0;
        flush_de_c  = 1'b0;
        flush_ex_c  = 1'b0;

        case (state_q)
            RUN: begin
                // The cycle after a timeout ignores the still-pending request.
                if (mem_busy && !mem_err_q) begin
                    freeze     = 1'b1;
                    wait_cnt_d = 8'd1;
                    state_d    = MEM_WAIT;
                end else begin
                    resolve = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    resolve    = 1'b1;
                    wait_cnt_d = 8'd0;
                    state_d    = RUN;
                end else begin
                    freeze = 1'b1;
                    if (wait_cnt_q >= WAIT_LAST) begin
                        wait_cnt_d = 8'd0;
                        mem_err_d  = 1'b1;
                        state_d    = RUN;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            FLUSH: begin
                flush_de_c  = 1'b1;
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q <= 2'd1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        // Branch and load-use act only when no freeze is in effect this cycle.
        if (resolve) begin
            if (br_taken) begin
                flush_de_c = 1'b1;
                flush_ex_c = 1'b1;
                if (BR_PENALTY > 1) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FLUSH_INIT;
                end
            end else if (load_use) begin
                lu_stall   = 1'b1;
                flush_ex_c = 1'b1;
            end
        end
    end

    // Reset forces every control output quiet, independent of the inputs.
    assign stall_if  = rst_n && (freeze || lu_stall);
    assign stall_de  = rst_n && (freeze || lu_stall);
    assign stall_ex  = rst_n && freeze;
    assign flush_de  = rst_n && flush_de_c;
    assign flush_ex  = rst_n && flush_ex_c;
    assign fwd_a     = rst_n && !flush_de_c && ex_fwd && match_rs1;
    assign fwd_b     = rst_n && !flush_de_c && ex_fwd && match_rs2;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_cnt_q  <= 8'd0;
            flush_cnt_q <= 2'd0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
            if (stall_if && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with BR_PENALTY=3 and MEM_TIMEOUT=4.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_de, instr_ex;
    logic        reg_write_ex, br_taken, dmem_req, dmem_ready;
    logic        stall_if, stall_de, stall_ex, flush_de, flush_ex, fwd_a, fwd_b, mem_err;
    logic [31:0] stall_cnt;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // Output vector order: stall_if stall_de stall_ex flush_de flush_ex fwd_a fwd_b mem_err
    localparam logic [31:0] O_NONE   = 32'h00;
    localparam logic [31:0] O_FREEZE = 32'hE0;
    localparam logic [31:0] O_LU     = 32'hC8;
    localparam logic [31:0] O_BR     = 32'h18;
    localparam logic [31:0] O_FLD    = 32'h10;
    localparam logic [31:0] O_FWD2   = 32'h06;
    localparam logic [31:0] O_FWDA   = 32'h04;
    localparam logic [31:0] O_ERR    = 32'h01;

    hazard_controller #(
        .BR_PENALTY  (3),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_de     (instr_de),
        .instr_ex     (instr_ex),
        .reg_write_ex (reg_write_ex),
        .br_taken     (br_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .stall_if     (stall_if),
        .stall_de     (stall_de),
        .stall_ex     (stall_ex),
        .flush_de     (flush_de),
        .flush_ex     (flush_ex),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1);
        return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] outs();
        return {24'd0, stall_if, stall_de, stall_ex, flush_de, flush_ex, fwd_a, fwd_b, mem_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        instr_de     = NOP;
        instr_ex     = NOP;
        reg_write_ex = 1'b0;
        br_taken     = 1'b0;
        dmem_req     = 1'b0;
        dmem_ready   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();

        // Reset gates every output even with all hazards requested.
        dmem_req     = 1'b1;
        br_taken     = 1'b1;
        reg_write_ex = 1'b1;
        instr_ex     = r_add(5, 1, 2);
        instr_de     = r_add(6, 5, 5);
        #3;
        check("rst_outs", outs(), O_NONE);
        check("rst_cnt", stall_cnt, 32'd0);
        tick();
        tick();
        check("rst_hold_outs", outs(), O_NONE);
        check("rst_hold_cnt", stall_cnt, 32'd0);

        set_idle();
        rst_n = 1'b1;
        #1 check("idle", outs(), O_NONE);

        // Forwarding
        instr_ex = r_add(5, 1, 2); reg_write_ex = 1'b1; instr_de = r_add(6, 5, 5);
        #1 check("fwd_both", outs(), O_FWD2);
        reg_write_ex = 1'b0;
        #1 check("fwd_no_write", outs(), O_NONE);
        reg_write_ex = 1'b1; instr_de = addi(6, 5, 12'd5);
        #1 check("fwd_imm_rs1_only", outs(), O_FWDA);
        instr_ex = jal(5); instr_de = r_add(6, 5, 5);
        #1 check("fwd_jal_excluded", outs(), O_NONE);
        instr_ex = r_add(0, 1, 2); instr_de = r_add(6, 0, 0);
        #1 check("fwd_x0", outs(), O_NONE);
        tick();
        check("cnt_after_fwd", stall_cnt, 32'd0);

        // Load-use: store data register depends on the load
        instr_ex = lw(5, 1); instr_de = sw(5, 7);
        #1 check("lu_store", outs(), O_LU);
        tick();
        check("lu_cnt", stall_cnt, 32'd1);
        instr_ex = NOP;
        #1 check("lu_bubble", outs(), O_NONE);
        instr_ex = lw(0, 1); instr_de = r_add(6, 0, 0);
        #1 check("lu_x0", outs(), O_NONE);
        tick();

        // Memory wait: ready low for three cycles, load-use resolved on release
        set_idle();
        dmem_req = 1'b1;
        #1 check("mw_c0", outs(), O_FREEZE);
        tick();
        check("mw_c1", outs(), O_FREEZE);
        tick();
        check("mw_c2", outs(), O_FREEZE);
        tick();
        dmem_ready = 1'b1; instr_ex = lw(5, 1); instr_de = r_add(6, 5, 0);
        #1 check("mw_release_lu", outs(), O_LU);
        tick();
        set_idle();
        #1 check("mw_back_run", outs(), O_NONE);
        check("mw_cnt", stall_cnt, 32'd5);

        // Timeout: ready never arrives
        dmem_req = 1'b1;
        #1 check("to_c0", outs(), O_FREEZE);
        tick();
        check("to_c1", outs(), O_FREEZE);
        tick();
        check("to_c2", outs(), O_FREEZE);
        tick();
        check("to_c3", outs(), O_FREEZE);
        tick();
        check("to_err_pulse", outs(), O_ERR);
        check("to_cnt", stall_cnt, 32'd9);
        tick();
        check("to_pulse_gone", outs(), O_FREEZE);
        dmem_req = 1'b0;
        #1 check("to_idle", outs(), O_NONE);
        tick();
        check("to_cnt_hold", stall_cnt, 32'd9);

        // Branch held off by a freeze, then a three-cycle flush
        dmem_req = 1'b1; br_taken = 1'b1;
        #1 check("br_c0_freeze", outs(), O_FREEZE);
        tick();
        check("br_c1_freeze", outs(), O_FREEZE);
        tick();
        dmem_ready = 1'b1;
        #1 check("br_release", outs(), O_BR);
        tick();
        dmem_ready = 1'b0;
        instr_ex = r_add(5, 1, 2); reg_write_ex = 1'b1; instr_de = r_add(6, 5, 5);
        #1 check("br_flush2", outs(), O_FLD);
        tick();
        check("br_flush3", outs(), O_FLD);
        tick();
        dmem_req = 1'b0; br_taken = 1'b0;
        #1 check("br_done_fwd", outs(), O_FWD2);
        check("br_cnt", stall_cnt, 32'd11);

        // Asynchronous reset during the second memory-wait cycle
        set_idle();
        dmem_req = 1'b1;
        #1 check("rs_c0", outs(), O_FREEZE);
        tick();
        tick();
        check("rs_c2", outs(), O_FREEZE);
        check("rs_cnt_before", stall_cnt, 32'd13);
        rst_n = 1'b0;
        #1 check("rs_async_outs", outs(), O_NONE);
        check("rs_async_cnt", stall_cnt, 32'd0);
        tick();
        dmem_req = 1'b0;
        rst_n = 1'b1;
        #1 check("rs_release", outs(), O_NONE);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rs_no_err", outs(), O_NONE);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
